// File: rtl/jtpopeye_obj_scan.sv
// Object line scanner: walks the object buffer each line and queues hits.
// Optional per-line hit limit enabled by defining JTPOPEYE_OBJ_LIMIT_EN.
module jtpopeye_obj_scan #(
  parameter int OBJ_N   = 128,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        line_start,
  input  logic [7:0]  vrender,
  input  logic        dma_busy,
  output logic [7:0]  obj_addr,
  input  logic [28:0] obj_data,
  output logic        obj_valid,
  input  logic        obj_ready,
  output logic [7:0]  obj_code,
  output logic [7:0]  obj_x,
  output logic [3:0]  obj_row,
  output logic [2:0]  obj_pal,
  output logic        obj_hflip,
  output logic        obj_ovf
);

  typedef enum logic [1:0] {
    IDLE, READ, CHECK, DONE
  } state_t;

  localparam int DEPTH = 1 << FIFO_AW;

  state_t st, st_nxt;

  logic [7:0]  idx, lat_v, row;
  logic        hit, last, full;
  logic        push, pop, flush;
  logic        restart, adv;
  logic [23:0] mem [DEPTH];
  logic [23:0] din, head;
  logic [FIFO_AW:0] wr_ptr, rd_ptr;

  assign row  = lat_v + 8'd1 - obj_data[15:8];
  assign hit  = row[7:4] == 4'd0;
  assign last = idx == 8'(OBJ_N - 1);

  assign din = {
    obj_data[23:16],
    obj_data[7:0],
    row[3:0] ^ {4{obj_data[28]}},
    obj_data[26:24],
    obj_data[27]
  };

  assign full = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  assign obj_valid = wr_ptr != rd_ptr;
  assign pop       = obj_valid & obj_ready;
  assign head      = mem[rd_ptr[FIFO_AW-1:0]];
  assign obj_addr  = idx;

  assign {obj_code, obj_x, obj_row,
    obj_pal, obj_hflip} = head;

`ifdef JTPOPEYE_OBJ_LIMIT_EN
  logic [3:0] hits;
  logic       ovf, ovf_set, at_limit;

  assign at_limit = hits == 4'd8;
  assign obj_ovf  = ovf;
`else
  assign obj_ovf = 1'b0;
`endif

  // Next-state and per-cycle control strobes
  always_comb begin
    st_nxt  = st;
    push    = 1'b0;
    flush   = 1'b0;
    restart = 1'b0;
    adv     = 1'b0;
`ifdef JTPOPEYE_OBJ_LIMIT_EN
    ovf_set = 1'b0;
`endif
    if (dma_busy) begin
      st_nxt = IDLE;
      flush  = 1'b1;
    end else if (line_start) begin
      st_nxt  = READ;
      restart = 1'b1;
      flush   = (st == READ) || (st == CHECK);
    end else begin
      unique case (st)
        READ: st_nxt = CHECK;
        CHECK: begin
          if (!hit) adv = 1'b1;
`ifdef JTPOPEYE_OBJ_LIMIT_EN
          else if (at_limit) begin
            ovf_set = 1'b1;
            st_nxt  = DONE;
          end
`endif
          else if (!full) begin
            push = 1'b1;
            adv  = 1'b1;
          end
          if (adv) st_nxt = last ? DONE : READ;
        end
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else if (cen) st <= st_nxt;
  end

  // Scan index and latched line number
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= 8'd0;
      lat_v <= 8'd0;
    end else if (cen) begin
      if (dma_busy) idx <= 8'd0;
      else if (restart) begin
        idx   <= 8'd0;
        lat_v <= vrender;
      end else if (adv && !last) begin
        idx <= idx + 8'd1;
      end
    end
  end

`ifdef JTPOPEYE_OBJ_LIMIT_EN
  // Per-line hit counter and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      hits <= 4'd0;
      ovf  <= 1'b0;
    end else if (cen) begin
      if (dma_busy || restart) begin
        hits <= 4'd0;
        ovf  <= 1'b0;
      end else begin
        if (push) hits <= hits + 4'd1;
        if (ovf_set) ovf <= 1'b1;
      end
    end
  end
`endif

  // Hit FIFO; flush beats push and pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 24'd0;
    end else if (cen) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr[FIFO_AW-1:0]] <= din;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_obj_scan.sv
// Bench for jtpopeye_obj_scan: directed steps plus random lines
// checked against a per-line hit list computed from the buffer.
module tb_jtpopeye_obj_scan;

  localparam int OBJ_N = 128;
  localparam int BUDGET = 6000;

  logic        clk = 1'b0;
  logic        rst, cen, line_start, dma_busy, obj_ready;
  logic [7:0]  vrender, obj_addr, obj_code, obj_x;
  logic [28:0] obj_data;
  logic        obj_valid, obj_hflip, obj_ovf;
  logic [3:0]  obj_row;
  logic [2:0]  obj_pal;

  int checks = 0;
  int failures = 0;

  logic [28:0] ram [256];
  logic [23:0] expq [$];
  logic        exp_ovf;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (cen) obj_data <= ram[obj_addr];

  jtpopeye_obj_scan #(.OBJ_N(OBJ_N), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .line_start(line_start), .vrender(vrender),
    .dma_busy(dma_busy), .obj_addr(obj_addr),
    .obj_data(obj_data), .obj_valid(obj_valid),
    .obj_ready(obj_ready), .obj_code(obj_code),
    .obj_x(obj_x), .obj_row(obj_row),
    .obj_pal(obj_pal), .obj_hflip(obj_hflip),
    .obj_ovf(obj_ovf)
  );

  function automatic logic [28:0] ent(
    input logic [7:0] y, x, code,
    input logic [2:0] pal, input logic hf, vf);
    return {vf, hf, pal, code, y, x};
  endfunction

  task automatic chk(input string tag,
    input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
        tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_ram(input logic [7:0] v);
    for (int i = 0; i < 256; i++)
      ram[i] = ent(8'(v + 8'd1 - 8'h80), 8'd0, 8'd0,
        3'd0, 1'b0, 1'b0);
  endtask

  // Reference: list of objects the line should deliver, in index order
  task automatic build(input logic [7:0] v);
    int n;
    logic [7:0] r;
    logic [28:0] e;
    n = 0;
    expq.delete();
    for (int i = 0; i < OBJ_N; i++) begin
      e = ram[i];
      r = 8'(v + 8'd1 - e[15:8]);
      if (r < 8'd16) begin
        n++;
`ifdef JTPOPEYE_OBJ_LIMIT_EN
        if (n > 8) continue;
`endif
        expq.push_back({e[23:16], e[7:0],
          r[3:0] ^ {4{e[28]}}, e[26:24], e[27]});
      end
    end
`ifdef JTPOPEYE_OBJ_LIMIT_EN
    exp_ovf = n > 8;
`else
    exp_ovf = 1'b0;
`endif
  endtask

  task automatic start_line(input logic [7:0] v);
    build(v);
    tick();
    vrender = v;
    line_start = 1'b1;
    cen = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic drain(input int rdy_pct, input int cen_pct);
    int cens, cyc;
    logic [23:0] got;
    cens = 0;
    cyc = 0;
    while ((expq.size() != 0 || cens < 2 * OBJ_N + 8)
        && cyc < BUDGET) begin
      obj_ready = $urandom_range(99) < rdy_pct;
      cen = $urandom_range(99) < cen_pct;
      #1;
      if (obj_valid && obj_ready && cen) begin
        got = {obj_code, obj_x, obj_row, obj_pal, obj_hflip};
        if (expq.size() == 0) chk("extra_xfer", 32'(obj_valid), 0);
        else chk("xfer", 32'(got), 32'(expq.pop_front()));
      end
      if (cen) cens++;
      cyc++;
      tick();
    end
    chk("budget", 32'(cyc < BUDGET), 1);
    chk("missing", 32'(expq.size()), 0);
    cen = 1'b1;
    obj_ready = 1'b0;
    #1;
    chk("empty_end", 32'(obj_valid), 0);
    chk("ovf_end", 32'(obj_ovf), 32'(exp_ovf));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!obj_valid && n < 40) begin
      tick();
      n++;
    end
    chk("wait_valid", 32'(obj_valid), 1);
  endtask

  initial begin
    rst = 1'b1;
    cen = 1'b1;
    line_start = 1'b0;
    dma_busy = 1'b0;
    obj_ready = 1'b0;
    vrender = 8'd0;
    clear_ram(8'h1F);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(obj_valid), 0);
    chk("rst_ovf", 32'(obj_ovf), 0);
    chk("rst_addr", 32'(obj_addr), 0);
    chk("rst_data", 32'({obj_code, obj_x, obj_row,
      obj_pal, obj_hflip}), 0);

    // First-hit latency and field mapping
    ram[0] = ent(8'h20, 8'h33, 8'h44, 3'd5, 1'b1, 1'b0);
    start_line(8'h1F);
    #1;
    chk("lat_addr_k1", 32'(obj_addr), 0);
    chk("lat_valid_k1", 32'(obj_valid), 0);
    tick();
    chk("lat_addr_k2", 32'(obj_addr), 0);
    chk("lat_valid_k2", 32'(obj_valid), 0);
    tick();
    chk("lat_valid_k3", 32'(obj_valid), 1);
    chk("lat_addr_k3", 32'(obj_addr), 1);
    chk("lat_row", 32'(obj_row), 0);
    chk("lat_code", 32'(obj_code), 32'h44);
    chk("lat_x", 32'(obj_x), 32'h33);
    chk("lat_pal", 32'(obj_pal), 5);
    chk("lat_hflip", 32'(obj_hflip), 1);
    drain(100, 100);

    // Vertical flip
    clear_ram(8'h1F);
    ram[5] = ent(8'h20, 8'h01, 8'h02, 3'd3, 1'b0, 1'b1);
    start_line(8'h1F);
    wait_valid();
    chk("vflip_row", 32'(obj_row), 32'hF);
    drain(100, 100);

    // Row wrap-around and its miss case
    clear_ram(8'h05);
    ram[7] = ent(8'hF8, 8'h10, 8'h20, 3'd1, 1'b0, 1'b0);
    start_line(8'h05);
    wait_valid();
    chk("wrap_row", 32'(obj_row), 32'hE);
    drain(100, 100);
    start_line(8'h08);
    drain(100, 100);

    // Back-pressure stall with six hits
    clear_ram(8'h50);
    ram[3]  = ent(8'h51, 8'hA0, 8'h01, 3'd0, 1'b0, 1'b0);
    ram[10] = ent(8'h50, 8'hA1, 8'h02, 3'd1, 1'b1, 1'b0);
    ram[20] = ent(8'h4F, 8'hA2, 8'h03, 3'd2, 1'b0, 1'b1);
    ram[30] = ent(8'h4A, 8'hA3, 8'h04, 3'd3, 1'b1, 1'b1);
    ram[40] = ent(8'h45, 8'hA4, 8'h05, 3'd4, 1'b0, 1'b0);
    ram[50] = ent(8'h42, 8'hA5, 8'h06, 3'd5, 1'b0, 1'b0);
    start_line(8'h50);
    repeat (400) tick();
    chk("stall_valid", 32'(obj_valid), 1);
    chk("stall_addr", 32'(obj_addr), 40);
    repeat (3) tick();
    chk("stall_addr_held", 32'(obj_addr), 40);
    drain(100, 100);

    // Restart mid-scan flushes queued objects
    clear_ram(8'h3F);
    ram[0]  = ent(8'h40, 8'hB0, 8'h11, 3'd1, 1'b0, 1'b0);
    ram[2]  = ent(8'h3C, 8'hB1, 8'h12, 3'd2, 1'b0, 1'b0);
    ram[50] = ent(8'h80, 8'hB2, 8'h13, 3'd3, 1'b1, 1'b0);
    ram[60] = ent(8'h78, 8'hB3, 8'h14, 3'd4, 1'b0, 1'b1);
    start_line(8'h3F);
    repeat (12) tick();
    chk("abort_queued", 32'(obj_valid), 1);
    start_line(8'h7F);
    #1;
    chk("abort_flushed", 32'(obj_valid), 0);
    drain(100, 100);

    // DMA takes the buffer mid-scan
    clear_ram(8'h10);
    ram[1] = ent(8'h11, 8'hC0, 8'h21, 3'd1, 1'b0, 1'b0);
    ram[3] = ent(8'h0F, 8'hC1, 8'h22, 3'd2, 1'b1, 1'b0);
    start_line(8'h10);
    repeat (10) tick();
    chk("dma_pre_valid", 32'(obj_valid), 1);
    dma_busy = 1'b1;
    tick();
    chk("dma_valid", 32'(obj_valid), 0);
    chk("dma_addr", 32'(obj_addr), 0);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    dma_busy = 1'b0;
    repeat (4) tick();
    chk("dma_idle_valid", 32'(obj_valid), 0);
    chk("dma_idle_addr", 32'(obj_addr), 0);
    chk("dma_ovf", 32'(obj_ovf), 0);
    start_line(8'h10);
    drain(100, 100);

    // Ten hits on one line
    clear_ram(8'h90);
    for (int i = 0; i < 10; i++)
      ram[5 + i] = ent(8'(8'h91 - 8'(i)), 8'(i),
        8'(8'h60 + i), 3'(i), 1'(i), 1'(i >> 1));
    start_line(8'h90);
    drain(100, 100);
    repeat (5) tick();
    chk("ovf_hold", 32'(obj_ovf), 32'(exp_ovf));
    start_line(8'h60);
    #1;
    chk("ovf_clear", 32'(obj_ovf), 0);
    drain(100, 100);

    // Random lines with random ready and clock enable
    for (int l = 0; l < 8; l++) begin
      logic [7:0] v;
      v = 8'($urandom);
      for (int i = 0; i < 256; i++)
        ram[i] = ent(8'(v + 8'd1 - 8'($urandom_range(0, 60))),
          8'($urandom), 8'($urandom), 3'($urandom),
          1'($urandom), 1'($urandom));
      start_line(v);
      drain($urandom_range(30, 100), $urandom_range(50, 100));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
